// File: rtl/st_issue_queue.sv
// Store issue queue: a DEPTH-entry FIFO between the issue stage and the store unit, with a
// page-offset match against all occupied entries. lsu_ctrl_t must have vaddr as its leading field.

package config_pkg;
  typedef struct packed {
    int unsigned VLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64, TRANS_ID_BITS: 32'd3};
endpackage

module st_issue_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type lsu_ctrl_t = logic,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  lsu_ctrl_t                lsu_ctrl_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output lsu_ctrl_t                lsu_ctrl_o,
  input  logic                     pop_st_i,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_matches_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned CtrlW  = $bits(lsu_ctrl_t);
  localparam int unsigned VaddrW = CVA6Cfg.VLEN;

  lsu_ctrl_t           mem_q [DEPTH];
  lsu_ctrl_t           mem_d [DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                push, pop;
  logic [DEPTH-1:0]    entry_hit;
  logic                unused_offset_bits;

  assign ready_o    = (count_q != CntW'(DEPTH));
  assign valid_o    = (count_q != '0);
  assign lsu_ctrl_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  assign push = valid_i && ready_o && !flush_i;
  assign pop  = pop_st_i && valid_o && !flush_i;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (valid_i && !ready_o && !flush_i);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = lsu_ctrl_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  if (CtrlW >= VaddrW && VaddrW >= 12) begin : g_match
    localparam int unsigned Base = CtrlW - VaddrW;
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PtrW-1:0] rel;
      assign rel          = PtrW'(i) - rd_ptr_q;
      assign entry_hit[i] = ({1'b0, rel} < count_q) &&
                            (mem_q[i][Base+11:Base+3] == page_offset_i[11:3]);
    end
  end else begin : g_no_match
    assign entry_hit = '0;
  end

  assign page_offset_matches_o = |entry_hit;
  assign unused_offset_bits    = ^page_offset_i;

endmodule

// File: tb/tb_st_issue_queue.sv
// Directed bench for st_issue_queue (DEPTH=2) with hand-computed expectations.

module tb_st_issue_queue;

  typedef struct packed {
    logic [63:0] vaddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [7:0]  operation;
    logic [2:0]  trans_id;
  } lsu_ctrl_t;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, pop_st_i;
  lsu_ctrl_t   lsu_ctrl_i, lsu_ctrl_o;
  logic        ready_o, valid_o, page_offset_matches_o, overflow_o;
  logic [11:0] page_offset_i;
  logic [1:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  st_issue_queue #(
    .CVA6Cfg   (config_pkg::cva6_cfg_empty),
    .lsu_ctrl_t(lsu_ctrl_t),
    .DEPTH     (2)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .valid_i              (valid_i),
    .lsu_ctrl_i           (lsu_ctrl_i),
    .ready_o              (ready_o),
    .valid_o              (valid_o),
    .lsu_ctrl_o           (lsu_ctrl_o),
    .pop_st_i             (pop_st_i),
    .page_offset_i        (page_offset_i),
    .page_offset_matches_o(page_offset_matches_o),
    .count_o              (count_o),
    .overflow_o           (overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the given controls for one clock edge, then release them and settle.
  task automatic step(input logic v, input logic [2:0] id, input logic [63:0] va,
                      input logic pop, input logic fl, input logic rst);
    valid_i             = v;
    lsu_ctrl_i          = '0;
    lsu_ctrl_i.trans_id = id;
    lsu_ctrl_i.vaddr    = va;
    lsu_ctrl_i.data     = {8{5'h0, id}};
    pop_st_i            = pop;
    flush_i             = fl;
    rst_i               = rst;
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
    pop_st_i = 1'b0;
    flush_i  = 1'b0;
    rst_i    = 1'b0;
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] cnt, input logic vld,
                           input logic rdy, input logic ovf);
    chk({tag, "_count"}, 64'(count_o), 64'(cnt));
    chk({tag, "_valid"}, 64'(valid_o), 64'(vld));
    chk({tag, "_ready"}, 64'(ready_o), 64'(rdy));
    chk({tag, "_ovf"}, 64'(overflow_o), 64'(ovf));
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; pop_st_i = 1'b0;
    lsu_ctrl_i = '0; page_offset_i = 12'h000;

    // Reset, with stray valid/pop that must be ignored.
    step(1'b1, 3'd7, 64'h0, 1'b1, 1'b0, 1'b1);
    chk_state("reset", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("reset_match", 64'(page_offset_matches_o), 64'd0);

    // Single push, one-cycle latency.
    step(1'b1, 3'd3, 64'h1238, 1'b0, 1'b0, 1'b0);
    chk_state("push1", 2'd1, 1'b1, 1'b1, 1'b0);
    chk("push1_id", 64'(lsu_ctrl_o.trans_id), 64'd3);

    // Offset match on [11:3].
    page_offset_i = 12'h23C; #1;
    chk("match_23c", 64'(page_offset_matches_o), 64'd1);
    page_offset_i = 12'h240; #1;
    chk("match_240", 64'(page_offset_matches_o), 64'd0);
    page_offset_i = 12'h23C; pop_st_i = 1'b1; #1;
    chk("match_popping", 64'(page_offset_matches_o), 64'd1);
    step(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_state("pop1", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("match_empty", 64'(page_offset_matches_o), 64'd0);

    // Pop while empty is ignored.
    step(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_state("pop_empty", 2'd0, 1'b0, 1'b1, 1'b0);

    // Fill, then push with pop while full: rejected, overflow set.
    step(1'b1, 3'd1, 64'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 64'h200, 1'b0, 1'b0, 1'b0);
    chk_state("full", 2'd2, 1'b1, 1'b0, 1'b0);
    chk("full_head", 64'(lsu_ctrl_o.trans_id), 64'd1);
    step(1'b1, 3'd5, 64'h500, 1'b1, 1'b0, 1'b0);
    chk_state("ovf", 2'd1, 1'b1, 1'b1, 1'b1);
    chk("ovf_head", 64'(lsu_ctrl_o.trans_id), 64'd2);
    step(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_state("drain", 2'd0, 1'b0, 1'b1, 1'b1);

    // Interleaved push/pop across pointer wrap.
    step(1'b1, 3'd4, 64'h400, 1'b0, 1'b0, 1'b0);
    chk("wrap0_head", 64'(lsu_ctrl_o.trans_id), 64'd4);
    step(1'b1, 3'd5, 64'h500, 1'b1, 1'b0, 1'b0);
    chk("wrap1_head", 64'(lsu_ctrl_o.trans_id), 64'd5);
    chk("wrap1_count", 64'(count_o), 64'd1);
    step(1'b1, 3'd6, 64'h600, 1'b1, 1'b0, 1'b0);
    chk("wrap2_head", 64'(lsu_ctrl_o.trans_id), 64'd6);
    step(1'b1, 3'd7, 64'h700, 1'b1, 1'b0, 1'b0);
    chk("wrap3_head", 64'(lsu_ctrl_o.trans_id), 64'd7);
    chk("wrap3_count", 64'(count_o), 64'd1);
    step(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk_state("wrap_end", 2'd0, 1'b0, 1'b1, 1'b1);

    // Push and pop together while empty: push wins.
    step(1'b1, 3'd1, 64'h1000, 1'b1, 1'b0, 1'b0);
    chk_state("pp_empty", 2'd1, 1'b1, 1'b1, 1'b1);
    chk("pp_empty_id", 64'(lsu_ctrl_o.trans_id), 64'd1);

    // Flush with concurrent push while full: overflow stays set.
    step(1'b1, 3'd2, 64'h2000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 64'h3000, 1'b0, 1'b1, 1'b0);
    chk_state("flush1", 2'd0, 1'b0, 1'b1, 1'b1);

    // Reset mid-operation with pop asserted.
    step(1'b1, 3'd1, 64'h1238, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 64'h2000, 1'b0, 1'b0, 1'b0);
    page_offset_i = 12'h23C; #1;
    chk("pre_rst_match", 64'(page_offset_matches_o), 64'd1);
    step(1'b0, 3'd0, 64'h0, 1'b1, 1'b0, 1'b1);
    chk_state("mid_rst", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_match", 64'(page_offset_matches_o), 64'd0);

    // Flush while full with valid_i must not raise overflow.
    step(1'b1, 3'd4, 64'h400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 64'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 64'h600, 1'b1, 1'b1, 1'b0);
    chk_state("flush2", 2'd0, 1'b0, 1'b1, 1'b0);

    // Pointers restart at zero after flush.
    step(1'b1, 3'd3, 64'h300, 1'b0, 1'b0, 1'b0);
    chk_state("post_flush", 2'd1, 1'b1, 1'b1, 1'b0);
    chk("post_flush_id", 64'(lsu_ctrl_o.trans_id), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/st_issue_queue.md
ST_ISSUE_QUEUE -- requirements
Module: st_issue_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration (VLEN, TRANS_ID_BITS).
REQ-002 SHALL have parameter lsu_ctrl_t, default logic, store request record (vaddr, data, be, operation, trans_id).
REQ-003 SHALL have parameter DEPTH, default 2, entry count; power of two, >= 2.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  controller flush; discards all entries.
REQ-007 SHALL have port valid_i  input  1  issue stage presents a store request.
REQ-008 SHALL have port lsu_ctrl_i  input  lsu_ctrl_t  request payload.
REQ-009 SHALL have port ready_o  output  1  queue can accept a request this cycle.
REQ-010 SHALL have port valid_o  output  1  head entry valid, presented to store unit.
REQ-011 SHALL have port lsu_ctrl_o  output  lsu_ctrl_t  head entry payload.
REQ-012 SHALL have port pop_st_i  input  1  store unit consumed head entry.
REQ-013 SHALL have port page_offset_i  input  12  load address offset to check.
REQ-014 SHALL have port page_offset_matches_o  output  1  a queued store shares the offset.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have port overflow_o  output  1  sticky: push attempted while full.

Function
REQ-017 SHALL be a FIFO: read pointer, write pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter 0..DEPTH.
REQ-018 SHALL accept push when valid_i && ready_o && !flush_i; entry written at write pointer, pointer incremented.
REQ-019 SHALL drive ready_o = (count_o != DEPTH); no pass-through when full, even if pop_st_i asserted same cycle.
REQ-020 SHALL drive valid_o = (count_o != 0); latency push->valid_o one cycle; no combinational bypass input->output.
REQ-021 SHALL drive lsu_ctrl_o from entry at read pointer, registered, stable while valid_o && !pop_st_i.
REQ-022 SHALL perform pop when pop_st_i && valid_o && !flush_i; read pointer incremented; pop_st_i while empty ignored.
REQ-023 SHALL on simultaneous push and pop (non-full, non-empty) keep count unchanged and advance both pointers.
REQ-024 SHALL on simultaneous push and pop with count 0: push accepted, pop ignored, count becomes 1.
REQ-025 SHALL on flush_i reset both pointers and count to 0 next cycle, discarding any same-cycle push/pop; overflow_o unchanged.
REQ-026 SHALL set overflow_o when valid_i && !ready_o && !flush_i; cleared only by reset.
REQ-027 SHALL drive page_offset_matches_o combinationally: OR over occupied entries of (vaddr[11:3] == page_offset_i[11:3]); 0 when empty; entry being popped this cycle still counts.
REQ-028 SHALL hold payload storage without reset; only pointers, count, overflow are reset.

Reset
REQ-029 SHALL when rst_i is high at a rising edge set count_o=0, pointers=0, valid_o=0, ready_o=1, overflow_o=0, page_offset_matches_o=0.
REQ-030 SHALL give reset priority over flush_i, push, and pop; reset mid-operation drops all entries.
REQ-031 SHALL ignore valid_i/pop_st_i in the reset cycle.

Verification
REQ-032 Reset then push trans_id 3 at cycle 1 -> cycle 2 valid_o=1, lsu_ctrl_o.trans_id=3, count_o=1, ready_o=1.
REQ-033 DEPTH=2: push ids 1,2 back-to-back, third push id 5 with pop_st_i same cycle -> id 5 rejected, overflow_o=1, count_o=1, head id 2.
REQ-034 Push 4 entries, pop 4 interleaved, DEPTH=2 -> FIFO order preserved across pointer wrap, count_o returns 0, valid_o=0.
REQ-035 Two entries queued, flush_i with concurrent valid_i -> next cycle count_o=0, valid_o=0, overflow_o unchanged.
REQ-036 Entry vaddr=0x1238 queued, page_offset_i=0x23C -> matches_o=1; page_offset_i=0x240 -> 0; empty queue -> 0.
REQ-037 rst_i asserted with 2 entries and pop_st_i=1 -> next cycle count_o=0, overflow_o=0, ready_o=1.
